// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer,
// synchronous flush and saturating stall/flush performance counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W     = 97,
    parameter bit          FLUSH_ZERO = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // bit0 = main valid, bit1 = skid valid; handshake outputs come straight off these flops
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_d, skid_d;
    logic [DATA_W-1:0] main_nxt, skid_nxt;
    logic              main_v, skid_v;
    logic              fire_in, fire_out;

    assign main_v   = state[0];
    assign skid_v   = state[1];
    assign fire_in  = in_valid & ~skid_v;
    assign fire_out = main_v & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (fire_in) state_nxt = ONE;
                ONE: begin
                    if (fire_in && !fire_out) state_nxt = FULL;
                    else if (!fire_in && fire_out) state_nxt = EMPTY;
                end
                FULL: if (fire_out) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_nxt = main_d;
        skid_nxt = skid_d;
        if (flush) begin
            if (FLUSH_ZERO) begin
                main_nxt = '0;
                skid_nxt = '0;
            end
        end else begin
            unique case (state)
                EMPTY: if (fire_in) main_nxt = in_data;
                ONE: begin
                    if (fire_in && fire_out) main_nxt = in_data;
                    else if (fire_in) skid_nxt = in_data;
                end
                FULL: if (fire_out) main_nxt = skid_d;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (FLUSH_ZERO) begin
                main_d <= '0;
                skid_d <= '0;
            end
        end else begin
            main_d <= main_nxt;
            skid_d <= skid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (main_v && !out_ready && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (flush && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;
        end
    end

    always_comb begin
        out_valid = main_v;
        out_data  = main_d;
        in_ready  = ~skid_v;
        occupancy = {1'b0, main_v} + {1'b0, skid_v};
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed test-plan scenarios plus random traffic
// checked every cycle against a queue-based model, on two parameter sets.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [96:0] in_data;

    logic        ir_a, ov_a;
    logic [96:0] od_a;
    logic [1:0]  occ_a;
    logic [3:0]  st_a_dut, fc_a_dut;

    logic        ir_b, ov_b;
    logic [15:0] od_b;
    logic [1:0]  occ_b;
    logic [15:0] st_b_dut, fc_b_dut;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model state
    logic [96:0] q[$];
    logic [96:0] last_a = '0;
    logic [15:0] last_b = '0;
    bit          b_known = 1'b0;
    int          st_a = 0, fc_a = 0, st_b = 0, fc_b = 0;
    bit          m_fi, m_fo;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(97), .FLUSH_ZERO(1'b1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .occupancy(occ_a), .stall_cycles(st_a_dut), .flush_count(fc_a_dut)
    );

    pipe_stage_skid #(.DATA_W(16), .FLUSH_ZERO(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data[15:0]),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .occupancy(occ_b), .stall_cycles(st_b_dut), .flush_count(fc_b_dut)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a FIFO of at most two beats.
    always @(posedge clk) begin
        m_fi = in_valid && (q.size() < 2);
        m_fo = (q.size() > 0) && out_ready;
        if (rst) begin
            q.delete();
            st_a = 0; fc_a = 0; st_b = 0; fc_b = 0;
            last_a = '0;
            b_known = 1'b0;
        end else begin
            if (q.size() > 0 && !out_ready) begin
                if (st_a < 15) st_a++;
                if (st_b < 65535) st_b++;
            end
            if (flush) begin
                if (fc_a < 15) fc_a++;
                if (fc_b < 65535) fc_b++;
                q.delete();
                last_a = '0;
            end else begin
                if (m_fo) void'(q.pop_front());
                if (m_fi) q.push_back(in_data);
                if (q.size() > 0) begin
                    last_a = q[0];
                    last_b = q[0][15:0];
                    b_known = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_out_valid", 128'(ov_a), 128'(q.size() > 0));
            chk("a_in_ready", 128'(ir_a), 128'(q.size() < 2));
            chk("a_occupancy", 128'(occ_a), 128'(q.size()));
            chk("a_out_data", 128'(od_a), 128'(last_a));
            chk("a_stall", 128'(st_a_dut), 128'(st_a));
            chk("a_flush_cnt", 128'(fc_a_dut), 128'(fc_a));
            chk("b_out_valid", 128'(ov_b), 128'(q.size() > 0));
            chk("b_in_ready", 128'(ir_b), 128'(q.size() < 2));
            chk("b_occupancy", 128'(occ_b), 128'(q.size()));
            if (b_known) chk("b_out_data", 128'(od_b), 128'(last_b));
            chk("b_stall", 128'(st_b_dut), 128'(st_b));
            chk("b_flush_cnt", 128'(fc_b_dut), 128'(fc_b));
        end
    end

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [96:0] d, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [96:0] d;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        drive(1, 0, 0, 97'h0, 0);
        chk_en = 1'b1;
        chk("rst_in_ready", 128'(ir_a), 128'(1));
        chk("rst_out_valid", 128'(ov_a), 128'(0));
        chk("rst_occ", 128'(occ_a), 128'(0));
        chk("rst_stall", 128'(st_a_dut), 128'(0));
        chk("rst_flush", 128'(fc_a_dut), 128'(0));

        // streaming
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 1, 97'(k), 1);
            chk("stream_data", 128'(od_a), 128'(k));
            chk("stream_ready", 128'(ir_a), 128'(1));
            chk("stream_occ", 128'(occ_a), 128'(1));
        end
        drive(0, 0, 0, 97'h0, 1);
        chk("stream_drain", 128'(occ_a), 128'(0));

        // back-pressure
        drive(0, 0, 1, 97'hA, 0);
        chk("bp_occ1", 128'(occ_a), 128'(1));
        chk("bp_stall0", 128'(st_a_dut), 128'(0));
        drive(0, 0, 1, 97'hB, 0);
        chk("bp_occ2", 128'(occ_a), 128'(2));
        chk("bp_ready0", 128'(ir_a), 128'(0));
        chk("bp_stall1", 128'(st_a_dut), 128'(1));
        chk("bp_headA", 128'(od_a), 128'(97'hA));
        drive(0, 0, 1, 97'hD, 0);
        chk("bp_stall2", 128'(st_a_dut), 128'(2));
        chk("bp_holdA", 128'(od_a), 128'(97'hA));
        drive(0, 0, 0, 97'h0, 1);
        chk("bp_nextB", 128'(od_a), 128'(97'hB));
        chk("bp_ready1", 128'(ir_a), 128'(1));
        chk("bp_occ_after", 128'(occ_a), 128'(1));
        drive(0, 0, 0, 97'h0, 1);
        chk("bp_empty", 128'(ov_a), 128'(0));

        // flush with the stage full
        drive(0, 0, 1, 97'hE, 0);
        drive(0, 0, 1, 97'hF, 0);
        chk("fl_full", 128'(occ_a), 128'(2));
        drive(0, 1, 1, 97'hC, 0);
        chk("fl_valid", 128'(ov_a), 128'(0));
        chk("fl_occ", 128'(occ_a), 128'(0));
        chk("fl_count", 128'(fc_a_dut), 128'(1));
        chk("fl_zero", 128'(od_a), 128'(0));
        chk("fl_stall", 128'(st_a_dut), 128'(4));
        drive(0, 0, 0, 97'h0, 1);
        chk("fl_noC", 128'(ov_a), 128'(0));

        // flush with FLUSH_ZERO=0 keeps payload
        drive(0, 0, 1, 97'hABC, 0);
        drive(0, 1, 0, 97'h0, 0);
        chk("fz0_valid", 128'(ov_b), 128'(0));
        chk("fz0_data", 128'(od_b), 128'(16'h0ABC));
        chk("fz1_data", 128'(od_a), 128'(0));
        chk("fz_count", 128'(fc_b_dut), 128'(2));

        // saturation of the 4-bit stall counter
        drive(0, 0, 1, 97'h55, 0);
        for (int k = 0; k < 20; k++) drive(0, 0, 0, 97'h0, 0);
        chk("sat_a", 128'(st_a_dut), 128'(15));
        chk("sat_b", 128'(st_b_dut), 128'(25));
        drive(0, 0, 0, 97'h0, 0);
        chk("sat_hold", 128'(st_a_dut), 128'(15));

        // reset while full
        drive(0, 0, 1, 97'h66, 0);
        chk("rf_full", 128'(occ_a), 128'(2));
        drive(1, 0, 1, 97'h77, 1);
        chk("rf_occ", 128'(occ_a), 128'(0));
        chk("rf_ready", 128'(ir_a), 128'(1));
        chk("rf_stall", 128'(st_a_dut), 128'(0));
        chk("rf_flush", 128'(fc_b_dut), 128'(0));
        chk("rf_valid", 128'(ov_a), 128'(0));
        drive(0, 0, 0, 97'h0, 1);
        chk("rf_quiet", 128'(ov_a), 128'(0));

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[95:64] = $urandom;
            d[96]    = 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 9) < 7),
                  d,
                  ($urandom_range(0, 9) < 6));
        end
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 97'h0, 1);
        chk("end_empty", 128'(occ_a), 128'(0));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
